// File: rtl/hdmi_video_scheduler.sv
// hdmi_video_scheduler
//   Sequences the per-pixel-clock period type of an HDMI link (control, video preamble,
//   video guard band, active video). Owns the raster counters and sync generation, drives
//   the mode/control inputs of the three TMDS encoder channels, handshakes pixels from the
//   frame source and records underflow.
//
// Ports
//   pix_clk_i      pixel clock, the only clock
//   reset_n_i      synchronous reset, active-low
//   enable_i       run the raster while 1; when 0 the current frame finishes, then idle
//   pix_valid_i    source has a pixel for this cycle
//   clr_status_i   pulse; clears underflow_o and uf_count_o
//   pix_ready_o    pixel consumed this cycle (same as de_o)
//   de_o           active video cycle
//   mode_o         0 control, 1 preamble, 2 guard band, 3 video
//   ctl_b_o        {vsync, hsync} to the blue encoder
//   ctl_g_o        {CTL1, CTL0} to the green encoder
//   ctl_r_o        {CTL3, CTL2} to the red encoder
//   row_o          line index described by the other outputs
//   column_o       pixel index described by the other outputs
//   frame_start_o  one-cycle pulse at row 0, column 0
//   running_o      1 while the sequencer is not idle
//   underflow_o    sticky; a pixel was missing during de_o
//   uf_count_o     saturating count of underflow cycles
//
// Every output is a register loaded from the next raster position and next state, so all
// of them describe the same cycle as row_o/column_o.

module hdmi_video_scheduler #(
  parameter int unsigned HACTIVE   = 640,
  parameter int unsigned HFPORCH   = 16,
  parameter int unsigned HSYNC     = 96,
  parameter int unsigned HBPORCH   = 48,
  parameter logic        HSYNC_POL = 1'b0,
  parameter int unsigned VACTIVE   = 480,
  parameter int unsigned VFPORCH   = 10,
  parameter int unsigned VSYNC     = 2,
  parameter int unsigned VBPORCH   = 33,
  parameter logic        VSYNC_POL = 1'b0,
  parameter int unsigned PRE_LEN   = 8,
  parameter int unsigned GB_LEN    = 2
) (
  input  logic        pix_clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        pix_valid_i,
  input  logic        clr_status_i,
  output logic        pix_ready_o,
  output logic        de_o,
  output logic [1:0]  mode_o,
  output logic [1:0]  ctl_b_o,
  output logic [1:0]  ctl_g_o,
  output logic [1:0]  ctl_r_o,
  output logic [15:0] row_o,
  output logic [15:0] column_o,
  output logic        frame_start_o,
  output logic        running_o,
  output logic        underflow_o,
  output logic [15:0] uf_count_o
);

  localparam int unsigned HTOTAL = HACTIVE + HFPORCH + HSYNC + HBPORCH;
  localparam int unsigned VTOTAL = VACTIVE + VFPORCH + VSYNC + VBPORCH;

  localparam logic [15:0] HActW      = 16'(HACTIVE);
  localparam logic [15:0] HLastW     = 16'(HTOTAL - 1);
  localparam logic [15:0] HPreStartW = 16'(HTOTAL - PRE_LEN - GB_LEN);
  localparam logic [15:0] HGbStartW  = 16'(HTOTAL - GB_LEN);
  localparam logic [15:0] HSyncBegW  = 16'(HACTIVE + HFPORCH);
  localparam logic [15:0] HSyncEndW  = 16'(HACTIVE + HFPORCH + HSYNC);
  localparam logic [15:0] VActW      = 16'(VACTIVE);
  localparam logic [15:0] VActLastW  = 16'(VACTIVE - 1);
  localparam logic [15:0] VLastW     = 16'(VTOTAL - 1);
  localparam logic [15:0] VSyncBegW  = 16'(VACTIVE + VFPORCH);
  localparam logic [15:0] VSyncEndW  = 16'(VACTIVE + VFPORCH + VSYNC);

  localparam logic [1:0] ModeCtrl  = 2'd0;
  localparam logic [1:0] ModePre   = 2'd1;
  localparam logic [1:0] ModeGuard = 2'd2;
  localparam logic [1:0] ModeVideo = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic [15:0] row_q, row_d;
  logic [15:0] col_q, col_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  ctl_b_q, ctl_b_d;
  logic [1:0]  ctl_g_q, ctl_g_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;
  logic        running_q, running_d;
  logic        underflow_q, underflow_d;
  logic [15:0] uf_count_q, uf_count_d;

  logic frame_end;
  logic uf_event;

  assign frame_end = (row_q == VLastW) && (col_q == HLastW);
  // de_q describes the current cycle, so pix_valid_i is judged against it.
  assign uf_event  = de_q && !pix_valid_i;

  // State register.
  always_ff @(posedge pix_clk_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable_i) state_d = StRun;
      StRun:   if (!enable_i) state_d = StDrain;
      StDrain: begin
        if (enable_i) begin
          state_d = StRun;
        end else if (frame_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next raster position, then the decode of that position.
  always_comb begin
    logic active;
    logic next_line_active;
    logic in_pre;
    logic in_guard;

    // The raster only moves between two non-idle states; entering RUN shows the parked
    // position first, and falling back to IDLE parks at the top of vertical blanking.
    row_d = VActW;
    col_d = 16'd0;
    if ((state_q != StIdle) && (state_d != StIdle)) begin
      if (col_q == HLastW) begin
        col_d = 16'd0;
        row_d = (row_q == VLastW) ? 16'd0 : row_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
        row_d = row_q;
      end
    end

    active           = (state_d != StIdle);
    next_line_active = (row_d == VLastW) || (row_d < VActLastW);
    in_pre   = active && next_line_active && (col_d >= HPreStartW) && (col_d < HGbStartW);
    in_guard = active && next_line_active && (col_d >= HGbStartW);

    de_d = active && (row_d < VActW) && (col_d < HActW);
    if (de_d) begin
      mode_d = ModeVideo;
    end else if (in_pre) begin
      mode_d = ModePre;
    end else if (in_guard) begin
      mode_d = ModeGuard;
    end else begin
      mode_d = ModeCtrl;
    end

    ctl_g_d    = in_pre ? 2'b01 : 2'b00;
    ctl_b_d[0] = ((col_d >= HSyncBegW) && (col_d < HSyncEndW)) ? HSYNC_POL : ~HSYNC_POL;
    ctl_b_d[1] = ((row_d >= VSyncBegW) && (row_d < VSyncEndW)) ? VSYNC_POL : ~VSYNC_POL;
    fs_d       = active && (row_d == 16'd0) && (col_d == 16'd0);
    running_d  = active;
  end

  // Underflow status: a coincident clear keeps only this cycle's event.
  always_comb begin
    underflow_d = underflow_q;
    uf_count_d  = uf_count_q;
    if (clr_status_i) begin
      underflow_d = uf_event;
      uf_count_d  = {15'd0, uf_event};
    end else if (uf_event) begin
      underflow_d = 1'b1;
      if (uf_count_q != 16'hFFFF) begin
        uf_count_d = uf_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge pix_clk_i) begin
    if (!reset_n_i) begin
      row_q       <= VActW;
      col_q       <= 16'd0;
      mode_q      <= ModeCtrl;
      ctl_b_q     <= {~VSYNC_POL, ~HSYNC_POL};
      ctl_g_q     <= 2'b00;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      running_q   <= 1'b0;
      underflow_q <= 1'b0;
      uf_count_q  <= 16'd0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      mode_q      <= mode_d;
      ctl_b_q     <= ctl_b_d;
      ctl_g_q     <= ctl_g_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      running_q   <= running_d;
      underflow_q <= underflow_d;
      uf_count_q  <= uf_count_d;
    end
  end

  assign pix_ready_o   = de_q;
  assign de_o          = de_q;
  assign mode_o        = mode_q;
  assign ctl_b_o       = ctl_b_q;
  assign ctl_g_o       = ctl_g_q;
  // CTL2/CTL3 are only meaningful for data islands, which this block never schedules.
  assign ctl_r_o       = 2'b00;
  assign row_o         = row_q;
  assign column_o      = col_q;
  assign frame_start_o = fs_q;
  assign running_o     = running_q;
  assign underflow_o   = underflow_q;
  assign uf_count_o    = uf_count_q;

endmodule

// File: tb/tb_hdmi_video_scheduler.sv
// Self-checking bench for hdmi_video_scheduler. Three instances share one clock and run in
// parallel: A uses the default 640x480 timing (probe table + underflow sequence), B a tiny
// raster with positive sync polarity (random enable/reset/valid plus drain sequences), and
// C a wide raster that starves the source long enough to saturate uf_count.
// Every cycle each instance is compared against a raster model that works on a linear
// pixel index (row = idx / HTOTAL, column = idx % HTOTAL).

module tb_hdmi_video_scheduler;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, pre, gb;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    int st;   // 0 idle, 1 run, 2 drain
    int p;    // linear raster index
    bit uf;
    int cnt;
  } model_t;

  typedef struct packed {
    logic [15:0] row, col;
    logic [1:0]  mode, ctl_b, ctl_g, ctl_r;
    logic        de, rdy, fs, run, uf;
    logic [15:0] cnt;
  } obs_t;

  typedef struct { int k, row, col, mode, de, g, b, fs; } probe_t;

  localparam cfg_t CfgA = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2,
                            vbp: 33, pre: 8, gb: 2, hpol: 1'b0, vpol: 1'b0};
  localparam cfg_t CfgB = '{ha: 16, hfp: 2, hs: 3, hbp: 4, va: 6, vfp: 1, vs: 2,
                            vbp: 2, pre: 2, gb: 1, hpol: 1'b1, vpol: 1'b1};
  localparam cfg_t CfgC = '{ha: 240, hfp: 1, hs: 2, hbp: 3, va: 60, vfp: 1, vs: 1,
                            vbp: 1, pre: 2, gb: 1, hpol: 1'b0, vpol: 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------- DUT instances
  logic        rst_a_n, en_a, pv_a, clr_a;
  logic        rdy_a, de_a, fs_a, run_a, uf_a;
  logic [1:0]  mode_a, b_a, g_a, r_a;
  logic [15:0] row_a, col_a, cnt_a;

  logic        rst_b_n, en_b, pv_b, clr_b;
  logic        rdy_b, de_b, fs_b, run_b, uf_b;
  logic [1:0]  mode_b, b_b, g_b, r_b;
  logic [15:0] row_b, col_b, cnt_b;

  logic        rst_c_n, en_c, pv_c, clr_c;
  logic        rdy_c, de_c, fs_c, run_c, uf_c;
  logic [1:0]  mode_c, b_c, g_c, r_c;
  logic [15:0] row_c, col_c, cnt_c;

  hdmi_video_scheduler u_dut_a (
    .pix_clk_i(clk), .reset_n_i(rst_a_n), .enable_i(en_a), .pix_valid_i(pv_a),
    .clr_status_i(clr_a), .pix_ready_o(rdy_a), .de_o(de_a), .mode_o(mode_a),
    .ctl_b_o(b_a), .ctl_g_o(g_a), .ctl_r_o(r_a), .row_o(row_a), .column_o(col_a),
    .frame_start_o(fs_a), .running_o(run_a), .underflow_o(uf_a), .uf_count_o(cnt_a)
  );

  hdmi_video_scheduler #(
    .HACTIVE(16), .HFPORCH(2), .HSYNC(3), .HBPORCH(4), .HSYNC_POL(1'b1),
    .VACTIVE(6), .VFPORCH(1), .VSYNC(2), .VBPORCH(2), .VSYNC_POL(1'b1),
    .PRE_LEN(2), .GB_LEN(1)
  ) u_dut_b (
    .pix_clk_i(clk), .reset_n_i(rst_b_n), .enable_i(en_b), .pix_valid_i(pv_b),
    .clr_status_i(clr_b), .pix_ready_o(rdy_b), .de_o(de_b), .mode_o(mode_b),
    .ctl_b_o(b_b), .ctl_g_o(g_b), .ctl_r_o(r_b), .row_o(row_b), .column_o(col_b),
    .frame_start_o(fs_b), .running_o(run_b), .underflow_o(uf_b), .uf_count_o(cnt_b)
  );

  hdmi_video_scheduler #(
    .HACTIVE(240), .HFPORCH(1), .HSYNC(2), .HBPORCH(3), .HSYNC_POL(1'b0),
    .VACTIVE(60), .VFPORCH(1), .VSYNC(1), .VBPORCH(1), .VSYNC_POL(1'b0),
    .PRE_LEN(2), .GB_LEN(1)
  ) u_dut_c (
    .pix_clk_i(clk), .reset_n_i(rst_c_n), .enable_i(en_c), .pix_valid_i(pv_c),
    .clr_status_i(clr_c), .pix_ready_o(rdy_c), .de_o(de_c), .mode_o(mode_c),
    .ctl_b_o(b_c), .ctl_g_o(g_c), .ctl_r_o(r_c), .row_o(row_c), .column_o(col_c),
    .frame_start_o(fs_c), .running_o(run_c), .underflow_o(uf_c), .uf_count_o(cnt_c)
  );

  // ---------------------------------------------------------------- reference model
  function automatic obs_t expect_out(cfg_t c, model_t m);
    obs_t o;
    int ht, vt, r, col;
    bit run, vid, nxt, pre, gb;
    ht  = c.ha + c.hfp + c.hs + c.hbp;
    vt  = c.va + c.vfp + c.vs + c.vbp;
    run = (m.st != 0);
    r   = m.p / ht;
    col = m.p % ht;
    vid = run && (r < c.va) && (col < c.ha);
    nxt = (r == vt - 1) || (r < c.va - 1);
    pre = run && nxt && (col >= ht - c.pre - c.gb) && (col < ht - c.gb);
    gb  = run && nxt && (col >= ht - c.gb);
    o.row    = 16'(r);
    o.col    = 16'(col);
    o.mode   = vid ? 2'd3 : pre ? 2'd1 : gb ? 2'd2 : 2'd0;
    o.ctl_g  = pre ? 2'b01 : 2'b00;
    o.ctl_r  = 2'b00;
    o.ctl_b[0] = ((col >= c.ha + c.hfp) && (col < c.ha + c.hfp + c.hs)) ? c.hpol : ~c.hpol;
    o.ctl_b[1] = ((r >= c.va + c.vfp) && (r < c.va + c.vfp + c.vs)) ? c.vpol : ~c.vpol;
    o.de  = vid;
    o.rdy = vid;
    o.fs  = run && (m.p == 0);
    o.run = run;
    o.uf  = m.uf;
    o.cnt = 16'(m.cnt);
    return o;
  endfunction

  function automatic model_t model_reset(cfg_t c);
    model_t n;
    n.st  = 0;
    n.p   = c.va * (c.ha + c.hfp + c.hs + c.hbp);
    n.uf  = 1'b0;
    n.cnt = 0;
    return n;
  endfunction

  function automatic model_t model_step(cfg_t c, model_t m, bit en, bit pv, bit clr, bit rst);
    model_t n;
    obs_t   o;
    int     tot;
    bit     ev;
    if (rst) return model_reset(c);
    tot = (c.ha + c.hfp + c.hs + c.hbp) * (c.va + c.vfp + c.vs + c.vbp);
    n  = m;
    o  = expect_out(c, m);
    ev = o.de && !pv;
    if (clr) begin
      n.uf  = ev;
      n.cnt = ev ? 1 : 0;
    end else if (ev) begin
      n.uf = 1'b1;
      if (n.cnt < 65535) n.cnt = n.cnt + 1;
    end
    case (m.st)
      0: if (en) n.st = 1;
      1: begin
        if (!en) n.st = 2;
        n.p = (m.p + 1) % tot;
      end
      default: begin
        if (en) begin
          n.st = 1;
          n.p  = (m.p + 1) % tot;
        end else if (m.p == tot - 1) begin
          n = model_reset(c);
          n.uf  = (clr ? ev : (m.uf | ev));
          n.cnt = (clr ? (ev ? 1 : 0) : ((ev && m.cnt < 65535) ? m.cnt + 1 : m.cnt));
        end else begin
          n.p = m.p + 1;
        end
      end
    endcase
    return n;
  endfunction

  // ---------------------------------------------------------------- checking helpers
  function automatic string fmt(obs_t o);
    return $sformatf("row=%0d col=%0d mode=%0d de=%b rdy=%b b=%b g=%b r=%b fs=%b run=%b uf=%b cnt=%0d",
                     o.row, o.col, o.mode, o.de, o.rdy, o.ctl_b, o.ctl_g, o.ctl_r, o.fs,
                     o.run, o.uf, o.cnt);
  endfunction

  task automatic cmp(string tag, obs_t got, obs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %s | expected %s", tag, fmt(got), fmt(exp));
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic obs_t got_a();
    return '{row: row_a, col: col_a, mode: mode_a, ctl_b: b_a, ctl_g: g_a, ctl_r: r_a,
             de: de_a, rdy: rdy_a, fs: fs_a, run: run_a, uf: uf_a, cnt: cnt_a};
  endfunction
  function automatic obs_t got_b();
    return '{row: row_b, col: col_b, mode: mode_b, ctl_b: b_b, ctl_g: g_b, ctl_r: r_b,
             de: de_b, rdy: rdy_b, fs: fs_b, run: run_b, uf: uf_b, cnt: cnt_b};
  endfunction
  function automatic obs_t got_c();
    return '{row: row_c, col: col_c, mode: mode_c, ctl_b: b_c, ctl_g: g_c, ctl_r: r_c,
             de: de_c, rdy: rdy_c, fs: fs_c, run: run_c, uf: uf_c, cnt: cnt_c};
  endfunction

  model_t ma, mb, mc;
  int a_k;
  int a_fs_seen;

  task automatic step_a();
    ma = model_step(CfgA, ma, en_a, pv_a, clr_a, !rst_a_n);
    @(posedge clk);
    #1;
    a_k++;
    cmp($sformatf("A k=%0d", a_k), got_a(), expect_out(CfgA, ma));
    if (fs_a === 1'b1) a_fs_seen++;
  endtask

  task automatic step_b();
    mb = model_step(CfgB, mb, en_b, pv_b, clr_b, !rst_b_n);
    @(posedge clk);
    #1;
    cmp("B cycle", got_b(), expect_out(CfgB, mb));
  endtask

  task automatic step_c();
    mc = model_step(CfgC, mc, en_c, pv_c, clr_c, !rst_c_n);
    @(posedge clk);
    #1;
    cmp("C cycle", got_c(), expect_out(CfgC, mc));
  endtask

  // Source keeps up during video; outside it pix_valid is noise that must be ignored.
  task automatic walk_a(int k);
    obs_t e;
    while (a_k < k) begin
      e    = expect_out(CfgA, ma);
      pv_a = e.de ? 1'b1 : 1'($urandom_range(0, 1));
      step_a();
    end
  endtask

  task automatic steps_b(int n);
    for (int i = 0; i < n; i++) step_b();
  endtask

  // ---------------------------------------------------------------- instance A
  task automatic run_a_seq();
    probe_t tbl[20];
    bit     uf_done;
    // k counts cycles after the first running output at (480,0); a frame is 800x525.
    tbl[0]  = '{k: 0,     row: 480, col: 0,   mode: 0, de: 0, g: 0, b: 3, fs: 0};
    tbl[1]  = '{k: 655,   row: 480, col: 655, mode: 0, de: 0, g: 0, b: 3, fs: 0};
    tbl[2]  = '{k: 656,   row: 480, col: 656, mode: 0, de: 0, g: 0, b: 2, fs: 0};
    tbl[3]  = '{k: 751,   row: 480, col: 751, mode: 0, de: 0, g: 0, b: 2, fs: 0};
    tbl[4]  = '{k: 752,   row: 480, col: 752, mode: 0, de: 0, g: 0, b: 3, fs: 0};
    tbl[5]  = '{k: 795,   row: 480, col: 795, mode: 0, de: 0, g: 0, b: 3, fs: 0};
    tbl[6]  = '{k: 8000,  row: 490, col: 0,   mode: 0, de: 0, g: 0, b: 1, fs: 0};
    tbl[7]  = '{k: 9500,  row: 491, col: 700, mode: 0, de: 0, g: 0, b: 0, fs: 0};
    tbl[8]  = '{k: 9600,  row: 492, col: 0,   mode: 0, de: 0, g: 0, b: 3, fs: 0};
    tbl[9]  = '{k: 35190, row: 523, col: 790, mode: 0, de: 0, g: 0, b: 3, fs: 0};
    tbl[10] = '{k: 35989, row: 524, col: 789, mode: 0, de: 0, g: 0, b: 3, fs: 0};
    tbl[11] = '{k: 35990, row: 524, col: 790, mode: 1, de: 0, g: 1, b: 3, fs: 0};
    tbl[12] = '{k: 35997, row: 524, col: 797, mode: 1, de: 0, g: 1, b: 3, fs: 0};
    tbl[13] = '{k: 35998, row: 524, col: 798, mode: 2, de: 0, g: 0, b: 3, fs: 0};
    tbl[14] = '{k: 35999, row: 524, col: 799, mode: 2, de: 0, g: 0, b: 3, fs: 0};
    tbl[15] = '{k: 36000, row: 0,   col: 0,   mode: 3, de: 1, g: 0, b: 3, fs: 1};
    tbl[16] = '{k: 36639, row: 0,   col: 639, mode: 3, de: 1, g: 0, b: 3, fs: 0};
    tbl[17] = '{k: 36640, row: 0,   col: 640, mode: 0, de: 0, g: 0, b: 3, fs: 0};
    tbl[18] = '{k: 36790, row: 0,   col: 790, mode: 1, de: 0, g: 1, b: 3, fs: 0};
    tbl[19] = '{k: 37598, row: 1,   col: 798, mode: 2, de: 0, g: 0, b: 3, fs: 0};

    ma = model_reset(CfgA);
    a_k = 0;
    a_fs_seen = 0;
    rst_a_n = 1'b0; en_a = 1'b0; pv_a = 1'b0; clr_a = 1'b0;
    step_a();
    step_a();
    chk("A reset row", row_a, 480);
    chk("A reset column", col_a, 0);
    chk("A reset ctl_b", b_a, 3);
    chk("A reset running", run_a, 0);
    rst_a_n = 1'b1;
    step_a();
    chk("A idle holds row", row_a, 480);
    en_a = 1'b1;
    a_k = -1;
    a_fs_seen = 0;
    step_a();
    chk("A first running", run_a, 1);

    uf_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!uf_done && tbl[i].k > 36020) begin
        walk_a(36020);
        // Five missing pixels, then a sixth coinciding with a clear, then a bare clear.
        pv_a = 1'b0;
        for (int j = 0; j < 5; j++) step_a();
        chk("A underflow after 5", uf_a, 1);
        chk("A uf_count after 5", cnt_a, 5);
        clr_a = 1'b1;
        step_a();
        chk("A underflow clr+miss", uf_a, 1);
        chk("A uf_count clr+miss", cnt_a, 1);
        pv_a = 1'b1;
        step_a();
        chk("A underflow cleared", uf_a, 0);
        chk("A uf_count cleared", cnt_a, 0);
        clr_a = 1'b0;
        uf_done = 1'b1;
      end
      walk_a(tbl[i].k);
      chk($sformatf("A probe %0d row", i), row_a, tbl[i].row);
      chk($sformatf("A probe %0d col", i), col_a, tbl[i].col);
      chk($sformatf("A probe %0d mode", i), mode_a, tbl[i].mode);
      chk($sformatf("A probe %0d de", i), de_a, tbl[i].de);
      chk($sformatf("A probe %0d ctl_g", i), g_a, tbl[i].g);
      chk($sformatf("A probe %0d ctl_b", i), b_a, tbl[i].b);
      chk($sformatf("A probe %0d frame_start", i), fs_a, tbl[i].fs);
    end
    chk("A frame_start pulses", a_fs_seen, 1);
  endtask

  // ---------------------------------------------------------------- instance B
  // Raster 25x11, parked position (6,0) = index 150, frame of 275 cycles.
  task automatic run_b_seq();
    mb = model_reset(CfgB);
    rst_b_n = 1'b0; en_b = 1'b0; pv_b = 1'b0; clr_b = 1'b0;
    steps_b(2);
    chk("B reset ctl_b", b_b, 0);
    rst_b_n = 1'b1;
    en_b = 1'b1;
    for (int i = 0; i < 600; i++) begin
      pv_b  = ($urandom_range(0, 9) < 7);
      clr_b = ($urandom_range(0, 39) == 0);
      step_b();
    end
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 79) == 0) en_b = ~en_b;
      rst_b_n = ($urandom_range(0, 599) != 0);
      pv_b    = ($urandom_range(0, 9) < 7);
      clr_b   = ($urandom_range(0, 49) == 0);
      step_b();
    end

    // Mid-frame reset, then a clean start.
    rst_b_n = 1'b0; clr_b = 1'b0; pv_b = 1'b1; en_b = 1'b1;
    step_b();
    chk("B reset row", row_b, 6);
    chk("B reset running", run_b, 0);
    chk("B reset uf_count", cnt_b, 0);
    rst_b_n = 1'b1;
    step_b();
    chk("B start row", row_b, 6);
    chk("B start running", run_b, 1);
    steps_b(125);
    chk("B wrap frame_start", fs_b, 1);
    chk("B wrap mode", mode_b, 3);
    steps_b(122);
    chk("B row4 col22 mode", mode_b, 1);
    chk("B row4 col22 ctl_g", g_b, 1);
    steps_b(2);
    chk("B row4 col24 mode", mode_b, 2);
    steps_b(23);
    chk("B last active row col22 mode", mode_b, 0);
    chk("B last active row col22 ctl_g", g_b, 0);
    steps_b(2);
    chk("B last active row col24 mode", mode_b, 0);

    // Drop enable at (8,0), restore it at (9,5): no gap in the raster.
    steps_b(51);
    en_b = 1'b0;
    steps_b(30);
    chk("B draining running", run_b, 1);
    en_b = 1'b1;
    step_b();
    chk("B re-enable row", row_b, 9);
    chk("B re-enable col", col_b, 6);
    chk("B re-enable running", run_b, 1);
    steps_b(44);
    chk("B after re-enable frame_start", fs_b, 1);

    // Drop enable at (2,0): drain through (10,24), then park at (6,0).
    steps_b(50);
    en_b = 1'b0;
    steps_b(224);
    chk("B drain last row", row_b, 10);
    chk("B drain last col", col_b, 24);
    chk("B drain last running", run_b, 1);
    step_b();
    chk("B idle row", row_b, 6);
    chk("B idle col", col_b, 0);
    chk("B idle running", run_b, 0);
    chk("B idle ctl_b", b_b, 0);
    step_b();
    chk("B idle held", row_b, 6);
  endtask

  // ---------------------------------------------------------------- instance C
  // 246x63 raster, 14400 active pixels per frame; 72000 starved cycles exceed 65535 misses.
  task automatic run_c_seq();
    mc = model_reset(CfgC);
    rst_c_n = 1'b0; en_c = 1'b0; pv_c = 1'b0; clr_c = 1'b0;
    step_c();
    step_c();
    rst_c_n = 1'b1;
    en_c = 1'b1;
    for (int i = 0; i < 72000; i++) step_c();
    chk("C uf_count saturated", cnt_c, 32'h0000_FFFF);
    chk("C underflow sticky", uf_c, 1);
  endtask

  initial begin
    fork
      run_a_seq();
      run_b_seq();
      run_c_seq();
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
